rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Round-robin arbiter that shares one downstream resource among N requesters, such as a shared gate-level datapath slice or a result bus. It grants exactly one requester at a time and holds the grant while that requester keeps its request high. Fairness is enforced with a rotating priority pointer and a bounded hold time: a contended owner is preempted after MAX_HOLD cycles. The block sits between requester logic and the resource's input mux select in the gate library's larger assemblies.

## Interface
- N, 4: number of requesters; N >= 2, need not be a power of two.
- MAX_HOLD, 4: maximum consecutive grant cycles for one owner while any other request is pending; MAX_HOLD >= 2.
- CLK  input  1  rising-edge clock; single clock domain.
- RST_N  input  1  reset; synchronous and active-low.
- REQ  input  N  request vector; bit i is held high by requester i for as long as it needs the resource.
- GNT  output  N  one-hot grant, or all zeros when idle; registered.
- GNT_ID  output  clog2(N)  binary index of the current owner; holds its last value when idle; registered.
- BUSY  output  1  equals |GNT; registered.
- PREEMPT  output  1  one-cycle pulse in the first cycle of a grant that was produced by forced preemption; registered.

## Operation
- State is {IDLE, GRANT}, plus owner index g, rotate pointer PTR (0..N-1) and hold counter HCNT (width clog2(MAX_HOLD)).
- Pick function: starting at index s and wrapping modulo N, return the first set bit of a masked request vector.
- IDLE:
  - If REQ != 0: grant pick(REQ, PTR), set HCNT=0, go to GRANT.
  - Otherwise stay in IDLE with GNT=0.
- GRANT, owner g, evaluated at each edge in this order:
  1. Release when REQ[g]==0. Set PTR=(g+1)%N. If REQ has other bits set, grant pick(REQ, (g+1)%N) at the same edge with no dead cycle and HCNT=0. Otherwise go to IDLE.
  2. Preempt when REQ[g]==1, HCNT==MAX_HOLD-1 and (REQ & ~(1<<g)) != 0. Grant pick(REQ & ~(1<<g), (g+1)%N), set PTR=(g+1)%N, HCNT=0, PREEMPT=1 for one cycle. The preempted requester keeps REQ high and re-competes normally.
  3. Otherwise keep g. HCNT increments and saturates at MAX_HOLD-1, so an uncontended owner holds indefinitely.
- A request that rises and falls between edges is never seen. A request must stay high until it is granted.
- Simultaneous release by the owner and a new request from the same index: the owner is treated as released. The same index can win again only if no other bit is set at that edge.
- Invariants: GNT is always one-hot or zero. GNT[i]==1 implies GNT_ID==i.

## Timing
- Latency from REQ rising to GNT is 1 cycle: REQ sampled at edge k gives GNT valid after edge k.
- Owner handover takes 0 idle cycles: the new GNT appears at the edge where the old REQ is sampled low.
- With contention, each owner holds for at most MAX_HOLD cycles, and every requester is granted within (N-1)*MAX_HOLD + 1 cycles.
- Reset values: GNT=0, GNT_ID=0, BUSY=0, PREEMPT=0, PTR=0, HCNT=0, state=IDLE.
- Reset mid-grant: at the first edge with RST_N low, all outputs take their reset values, whatever the state of REQ. After RST_N is released, arbitration restarts from PTR=0.

## Structure
- Shared package arb_pkg: state encoding constants (ST_IDLE, ST_GRANT) and a clog2 helper function used for the GNT_ID and HCNT widths.
- Sub-module rr_pick: combinational rotating-priority picker. Inputs: vector [N], start index. Outputs: onehot [N], index, found. One instance serves both the idle pick and the handover/preempt pick; the caller selects the mask and start index.
- The top level holds the state register, PTR, HCNT and output registers only.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
- Reset: RST_N low 2 cycles with REQ=1111 -> GNT=0000, BUSY=0, PREEMPT=0. First edge after release -> GNT=0001, GNT_ID=0.
- Single requester: REQ=0100 held for 10 cycles, then 0000 -> GNT=0100 for 10 cycles (no preempt, HCNT saturates), then GNT=0000 and BUSY=0 on the edge that samples REQ=0000.
- Handover: owner 0 drops while REQ=0110 -> the next edge gives GNT=0010, PTR=1, no idle cycle. When requester 1 drops -> GNT=0100.
- Preemption: REQ=1111 held constant -> grants 0001, 0010, 0100, 1000, 0001 with 4 cycles each. PREEMPT pulses in the first cycle of every grant after the first.
- Wrap and fairness: owner 3 releases with REQ=0101 -> GNT=0001 (search wraps from index 0), then 0100 after requester 0 releases. No requester waits more than 13 cycles.
- Mid-operation reset: RST_N low for one edge while GNT=0100 and REQ=0110 -> GNT=0000. After release -> GNT=0010 (PTR restarted at 0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and a
// width helper for index and hold-counter signals.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Bits needed to encode values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: scans the vector starting at the
// given index, wrapping modulo N, and reports the first set bit found.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          vec_i,
  input  logic [clog2(N)-1:0]   start_i,
  output logic [N-1:0]          onehot_o,
  output logic [clog2(N)-1:0]   idx_o,
  output logic                  found_o
);

  localparam int IW = clog2(N);

  logic [IW-1:0] scanIdx;

  // Walk the N positions in priority order and latch onto the first request.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    scanIdx  = '0;
    for (int k = 0; k < N; k++) begin
      scanIdx = IW'((int'(start_i) + k) % N);
      if (!found_o && vec_i[scanIdx]) begin
        found_o           = 1'b1;
        onehot_o[scanIdx] = 1'b1;
        idx_o             = scanIdx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded hold time. One requester owns the resource
// at a time; a contended owner is preempted after MAX_HOLD cycles, and the
// rotate pointer moves past each owner that releases or is preempted.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N-1:0]          req_i,
  output logic [N-1:0]          gnt_o,
  output logic [clog2(N)-1:0]   gntId_o,
  output logic                  busy_o,
  output logic                  preempt_o
);

  localparam int IW = clog2(N);
  localparam int HW = clog2(MAX_HOLD);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gntId_q, gntId_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          busy_q, busy_d;
  logic          preempt_q, preempt_d;

  logic [N-1:0]  pickVec, pickOnehot;
  logic [IW-1:0] pickStart, pickIdx, nextIdx;
  logic          pickFound;
  logic          ownerReq, othersReq, holdFull, doRelease, doPreempt;

  assign nextIdx   = (gntId_q == IW'(N - 1)) ? '0 : gntId_q + 1'b1;
  assign ownerReq  = |(req_i & gnt_q);
  assign othersReq = |(req_i & ~gnt_q);
  assign holdFull  = (hcnt_q == HW'(MAX_HOLD - 1));
  assign doRelease = (state_q == ST_GRANT) && !ownerReq;
  assign doPreempt = (state_q == ST_GRANT) && ownerReq && holdFull && othersReq;

  // When idle the whole request vector competes from the pointer; when owned,
  // the owner is masked out and the search starts just past it. On release the
  // owner bit is already low, so the same mask serves both handover cases.
  assign pickVec   = (state_q == ST_IDLE) ? req_i : (req_i & ~gnt_q);
  assign pickStart = (state_q == ST_IDLE) ? ptr_q : nextIdx;

  rr_pick #(
    .N(N)
  ) u_pick (
    .vec_i   (pickVec),
    .start_i (pickStart),
    .onehot_o(pickOnehot),
    .idx_o   (pickIdx),
    .found_o (pickFound)
  );

  // State, pointer, hold counter and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      gnt_q     <= '0;
      gntId_q   <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt_q     <= gnt_d;
      gntId_q   <= gntId_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  // Next state, rotate pointer and hold counter; release takes precedence over
  // preemption, and an uncontended owner just saturates the counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pickFound) begin
          state_d = ST_GRANT;
          hcnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (doRelease) begin
          ptr_d   = nextIdx;
          hcnt_d  = '0;
          state_d = pickFound ? ST_GRANT : ST_IDLE;
        end else if (doPreempt) begin
          ptr_d  = nextIdx;
          hcnt_d = '0;
        end else if (!holdFull) begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next grant, owner index and preempt pulse; the index holds when idle.
  always_comb begin
    gnt_d     = gnt_q;
    gntId_d   = gntId_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pickFound) begin
          gnt_d   = pickOnehot;
          gntId_d = pickIdx;
        end else begin
          gnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (doRelease) begin
          if (pickFound) begin
            gnt_d   = pickOnehot;
            gntId_d = pickIdx;
          end else begin
            gnt_d = '0;
          end
        end else if (doPreempt) begin
          gnt_d     = pickOnehot;
          gntId_d   = pickIdx;
          preempt_d = 1'b1;
        end
      end
      default: gnt_d = '0;
    endcase
    busy_d = |gnt_d;
  end

  assign gnt_o     = gnt_q;
  assign gntId_o   = gntId_q;
  assign busy_o    = busy_q;
  assign preempt_o = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Testbench for rr_arbiter (N=4, MAX_HOLD=4): directed request sequences plus
// a random tail, with expected outputs from a reference model queued per edge.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gntId;
  logic       busy;
  logic       preempt;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       preempt;
  } exp_t;

  exp_t       expQ[$];
  int         vectors     = 0;
  int         miscompares = 0;

  int         mOwner  = -1;
  int         mPtr    = 0;
  int         mHold   = 0;
  int         mLastId = 0;

  int         waitCnt[N];
  int         maxWait = 0;
  logic [3:0] sampledReq;
  logic       sampledRst;

  rr_arbiter #(
    .N(N),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rstN),
    .req_i    (req),
    .gnt_o    (gnt),
    .gntId_o  (gntId),
    .busy_o   (busy),
    .preempt_o(preempt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int firstFrom(input logic [3:0] v, input int s);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (s + k) % N;
      if (v[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic [3:0] r, input logic rn);
    exp_t       e;
    int         cand;
    logic [3:0] ownerBit;
    logic [3:0] others;
    e.preempt = 1'b0;
    if (!rn) begin
      mOwner  = -1;
      mPtr    = 0;
      mHold   = 0;
      mLastId = 0;
    end else if (mOwner < 0) begin
      cand = firstFrom(r, mPtr);
      if (cand >= 0) begin
        mOwner  = cand;
        mLastId = cand;
        mHold   = 0;
      end
    end else begin
      ownerBit = 4'(1) << mOwner;
      others   = r & ~ownerBit;
      if ((r & ownerBit) == 4'b0000) begin
        mPtr   = (mOwner + 1) % N;
        cand   = firstFrom(r, mPtr);
        mHold  = 0;
        mOwner = cand;
        if (cand >= 0) mLastId = cand;
      end else if (mHold == MAX_HOLD - 1 && others != 4'b0000) begin
        mPtr      = (mOwner + 1) % N;
        cand      = firstFrom(others, mPtr);
        mOwner    = cand;
        mLastId   = cand;
        mHold     = 0;
        e.preempt = 1'b1;
      end else if (mHold < MAX_HOLD - 1) begin
        mHold++;
      end
    end
    e.gnt  = (mOwner >= 0) ? (4'(1) << mOwner) : 4'b0000;
    e.id   = 2'(mLastId);
    e.busy = (mOwner >= 0);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rn);
    @(negedge clk);
    req        = r;
    rstN       = rn;
    sampledReq = r;
    sampledRst = rn;
    modelStep(r, rn);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    vectors++;
    assert (expQ.size() != 0) else begin
      miscompares++;
      $error("[TB] FAIL queue: observed=empty required=entry");
    end
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      vectors++;
      assert (gnt === e.gnt) else begin
        miscompares++;
        $error("[TB] FAIL gnt: observed=%b required=%b req=%b", gnt, e.gnt, sampledReq);
      end
      vectors++;
      assert (gntId === e.id) else begin
        miscompares++;
        $error("[TB] FAIL gntId: observed=%0d required=%0d", gntId, e.id);
      end
      vectors++;
      assert (busy === e.busy) else begin
        miscompares++;
        $error("[TB] FAIL busy: observed=%b required=%b", busy, e.busy);
      end
      vectors++;
      assert (preempt === e.preempt) else begin
        miscompares++;
        $error("[TB] FAIL preempt: observed=%b required=%b", preempt, e.preempt);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (sampledRst && sampledReq[i] && !gnt[i]) waitCnt[i]++;
      else waitCnt[i] = 0;
      if (waitCnt[i] > maxWait) maxWait = waitCnt[i];
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rn);
    applyStimulus(r, rn);
    checkOutput();
  endtask

  initial begin
    rstN = 1'b0;
    req  = 4'b0000;
    for (int i = 0; i < N; i++) waitCnt[i] = 0;

    $display("[TB] reset with all requests high, then full contention");
    repeat (2) step(4'b1111, 1'b0);
    repeat (20) step(4'b1111, 1'b1);

    $display("[TB] single requester holding past the hold limit");
    step(4'b0000, 1'b0);
    repeat (10) step(4'b0100, 1'b1);
    repeat (2) step(4'b0000, 1'b1);

    $display("[TB] zero-gap handover");
    repeat (2) step(4'b0001, 1'b1);
    step(4'b0111, 1'b1);
    repeat (2) step(4'b0110, 1'b1);
    repeat (2) step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);

    $display("[TB] pointer wrap from the top index");
    repeat (2) step(4'b1000, 1'b1);
    step(4'b1101, 1'b1);
    repeat (2) step(4'b0101, 1'b1);
    repeat (2) step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);

    $display("[TB] reset in the middle of a grant");
    repeat (2) step(4'b0100, 1'b1);
    step(4'b0110, 1'b1);
    step(4'b0110, 1'b0);
    repeat (2) step(4'b0110, 1'b1);
    step(4'b0000, 1'b1);

    $display("[TB] random request traffic");
    repeat (60) step(4'($urandom_range(0, 15)), 1'b1);

    vectors++;
    assert (maxWait <= (N - 1) * MAX_HOLD + 1) else begin
      miscompares++;
      $error("[TB] FAIL fairness: observed=%0d required<=%0d", maxWait, (N - 1) * MAX_HOLD + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
